hit_scorer: RTL

- Scoring stage directly downstream of light_controller and keypad_controller.
- Pairs each mole (lit LED) with keypad presses and classifies every mole as hit or missed.
- Accumulates points, misses and lives, and raises game_over according to the selected game mode.
- Outputs feed two_digit_decoder (points, remaining moles) and the top-level state machine (game_over).

---
 rtl/wam_pkg.sv | 20 ++
 rtl/sat_counter.sv | 44 ++++
 rtl/hit_scorer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/wam_pkg.sv
// Shared encodings for the whack-a-mole datapath: game modes, scorer states
// and the two-digit display ceiling.
package wam_pkg;

    localparam logic [1:0] MODE_NORMAL     = 2'd0;
    localparam logic [1:0] MODE_TIMED      = 2'd1;
    localparam logic [1:0] MODE_DEATHMATCH = 2'd2;
    localparam logic [1:0] MODE_LIVES      = 2'd3;

    localparam int SCORE_MAX = 99;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_UP,
        ST_DOWN,
        ST_OVER
    } scorer_state_t;

endpackage

// File: rtl/sat_counter.sv
// Load / increment / decrement counter that saturates at max_val going up
// and at zero going down. Load wins over inc, inc wins over dec.
module sat_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            if (count_q < max_val) begin
                count_d = count_q + W'(1);
            end
        end else if (dec) begin
            if (count_q != '0) begin
                count_d = count_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hit_scorer.sv
// Pairs each lit mole with keypad presses, classifies it as hit or missed,
// and keeps points, misses, remaining moles and lives for the display/FSM.
module hit_scorer
    import wam_pkg::*;
#(
    parameter int NUM_POS    = 9,
    parameter int CNT_W      = 7,
    parameter int LIVES_INIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] max_hits,
    input  logic             time_up,
    input  logic             light_on,
    input  logic [3:0]       light_pos,
    input  logic             key_valid,
    input  logic [3:0]       key,
    output logic [CNT_W-1:0] total_points,
    output logic [CNT_W-1:0] total_misses,
    output logic [CNT_W-1:0] moles_left,
    output logic [1:0]       lives_left,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic             game_over
);

    localparam logic [3:0] POS_LIMIT = 4'(NUM_POS);

    scorer_state_t state_q, state_d;
    logic [3:0]    mole_pos_q, mole_pos_d;
    logic          start_q;
    logic          hit_pulse_q, hit_pulse_d;
    logic          miss_pulse_q, miss_pulse_d;

    logic load, pts_inc, miss_inc, moles_dec, lives_dec;
    logic start_rise, key_match, life_mode, end_cond;

    assign start_rise = start && !start_q;
    assign key_match  = key_valid && (key == mole_pos_q) && (key < POS_LIMIT);
    assign life_mode  = (mode == MODE_DEATHMATCH) || (mode == MODE_LIVES);

    always_comb begin
        end_cond = 1'b0;
        case (mode)
            MODE_NORMAL:     end_cond = (moles_left == '0);
            MODE_TIMED:      end_cond = time_up;
            MODE_DEATHMATCH: end_cond = (total_misses != '0) || (moles_left == '0);
            MODE_LIVES:      end_cond = (lives_left == '0) || (moles_left == '0);
            default:         end_cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mole_pos_d   = mole_pos_q;
        load         = 1'b0;
        pts_inc      = 1'b0;
        miss_inc     = 1'b0;
        moles_dec    = 1'b0;
        lives_dec    = 1'b0;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;

        if (state_q == ST_IDLE || state_q == ST_OVER) begin
            if (start_rise) begin
                load    = 1'b1;
                state_d = ST_WAIT;
            end
        end else if (!start) begin
            state_d = ST_IDLE;
        end else if (end_cond) begin
            // Once the game is decided, no further event is scored.
            state_d = ST_OVER;
        end else if (state_q == ST_WAIT) begin
            if (light_on) begin
                mole_pos_d = light_pos;
                state_d    = ST_UP;
            end
        end else if (state_q == ST_UP) begin
            if (key_match) begin
                pts_inc     = 1'b1;
                hit_pulse_d = 1'b1;
                state_d     = light_on ? ST_DOWN : ST_WAIT;
                moles_dec   = !light_on;
            end else begin
                // A wrong press and a timeout in the same cycle are one miss.
                if (key_valid || !light_on) begin
                    miss_inc     = 1'b1;
                    miss_pulse_d = 1'b1;
                    lives_dec    = life_mode;
                end
                if (!light_on) begin
                    moles_dec = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
        end else if (state_q == ST_DOWN) begin
            if (!light_on) begin
                moles_dec = 1'b1;
                state_d   = ST_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mole_pos_q   <= '0;
            start_q      <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mole_pos_q   <= mole_pos_d;
            start_q      <= start;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_points (
        .clk(clk), .reset(reset), .load(load), .load_val('0),
        .inc(pts_inc), .dec(1'b0), .max_val(CNT_W'(SCORE_MAX)),
        .count(total_points)
    );

    sat_counter #(.W(CNT_W)) u_misses (
        .clk(clk), .reset(reset), .load(load), .load_val('0),
        .inc(miss_inc), .dec(1'b0), .max_val(CNT_W'(SCORE_MAX)),
        .count(total_misses)
    );

    // TIMED games have no mole budget, so the counter is parked at zero.
    sat_counter #(.W(CNT_W)) u_moles (
        .clk(clk), .reset(reset), .load(load),
        .load_val((mode == MODE_TIMED) ? '0 : max_hits),
        .inc(1'b0), .dec(moles_dec), .max_val(max_hits),
        .count(moles_left)
    );

    sat_counter #(.W(2)) u_lives (
        .clk(clk), .reset(reset), .load(load), .load_val(2'(LIVES_INIT)),
        .inc(1'b0), .dec(lives_dec), .max_val(2'(LIVES_INIT)),
        .count(lives_left)
    );

    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign game_over  = (state_q == ST_OVER);

endmodule
